// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing controller: owns PC and IR, reads program memory,
// hands ALU work to the datapath and resolves ARC conditional branches.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_FETCH  | RD high, address = PC; IR loaded on last wait-state edge
// S_DECODE | classify IR: fin word, branch, or datapath instruction
// S_EXEC   | one-cycle exec_start pulse to the datapath
// S_WAIT   | waiting for exec_done, then PC += 4
// S_BRANCH | sample flags, PC += disp or PC += 4
// S_HALT   | fin word seen; sticky until reset
module fetch_sequencer #(
  parameter int                       DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = DATAWIDTH_BUS'(32'h0000_0800),
  parameter int                       MEM_WAIT      = 0
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_InHigh,
  input  logic                     start,
  output logic                     RD,
  output logic                     WR,
  output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
  input  logic [DATAWIDTH_BUS-1:0] BusDatos,
  output logic [DATAWIDTH_BUS-1:0] IR,
  output logic [DATAWIDTH_BUS-1:0] PC,
  output logic                     exec_start,
  input  logic                     exec_done,
  input  logic                     cc_n,
  input  logic                     cc_z,
  input  logic                     cc_v,
  input  logic                     cc_c,
  output logic                     halted
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_BRANCH, S_HALT
  } state_t;

  state_t                   state, state_nxt;
  logic [3:0]               wait_cnt;
  logic                     is_branch;
  logic                     taken;
  logic [DATAWIDTH_BUS-1:0] disp;
  logic [DATAWIDTH_BUS-1:0] pc_inc;

  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (wait_cnt == 4'd0) state_nxt = S_DECODE;
      S_DECODE: begin
        if (IR == '0)     state_nxt = S_HALT;
        else if (is_branch) state_nxt = S_BRANCH;
        else              state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = S_WAIT;
      S_WAIT:   if (exec_done) state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign is_branch = (IR[31:30] == 2'b00) && (IR[24:22] == 3'b010);
  assign disp      = {{(DATAWIDTH_BUS-22){IR[21]}}, IR[21:0]};
  assign pc_inc    = PC + DATAWIDTH_BUS'(4);

  always_comb begin
    taken = 1'b0;
    case (IR[28:25])
      4'b0001: taken = cc_z;
      4'b0101: taken = cc_c;
      4'b0110: taken = cc_n;
      4'b0111: taken = cc_v;
      4'b1000: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Wait-state counter reloads whenever we are outside FETCH, so every fetch starts full.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      PC       <= RESET_PC;
      IR       <= '0;
      wait_cnt <= 4'd0;
    end else begin
      if (state == S_FETCH) begin
        if (wait_cnt == 4'd0) IR <= BusDatos;
        else                  wait_cnt <= wait_cnt - 4'd1;
      end else begin
        wait_cnt <= WAIT_LOAD;
      end
      if (state == S_WAIT && exec_done) PC <= pc_inc;
      if (state == S_BRANCH)            PC <= taken ? (PC + disp) : pc_inc;
    end
  end

  assign RD             = (state == S_FETCH);
  assign WR             = 1'b0;
  assign BusDirecciones = RD ? PC : '0;
  assign exec_start     = (state == S_EXEC);
  assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: instruction-level model of PC flow and per-cycle
// handshake expectations, driven by directed and random programs.
module tb_fetch_sequencer;
  localparam int          MW     = 3;
  localparam logic [31:0] RPC    = 32'h0000_0800;
  localparam int          NWORDS = 64;
  localparam logic [31:0] ALU_W  = 32'h8280_2001;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_InHigh = 1'b1;
  logic        start = 1'b0;
  logic        exec_done = 1'b0;
  logic        cc_n = 1'b0, cc_z = 1'b0, cc_v = 1'b0, cc_c = 1'b0;
  logic        RD, WR, exec_start, halted;
  logic [31:0] BusDirecciones, BusDatos, IR, PC;
  logic [31:0] junk = 32'hDEAD_BEEF;

  logic [31:0] prog [NWORDS];
  logic [31:0] hiw  [4];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer #(.DATAWIDTH_BUS(32), .RESET_PC(RPC), .MEM_WAIT(MW)) dut (
    .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh), .start(start),
    .RD(RD), .WR(WR), .BusDirecciones(BusDirecciones), .BusDatos(BusDatos),
    .IR(IR), .PC(PC), .exec_start(exec_start), .exec_done(exec_done),
    .cc_n(cc_n), .cc_z(cc_z), .cc_v(cc_v), .cc_c(cc_c), .halted(halted)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Program memory: a window at RESET_PC plus four words at the top of the address space.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RPC;
    if (a[1:0] == 2'b00 && a >= RPC && off < 32'(NWORDS * 4)) return prog[int'(off >> 2)];
    if (a[1:0] == 2'b00 && a >= 32'hFFFF_FFF0) return hiw[a[3:2]];
    return 32'h0;
  endfunction

  always_comb BusDatos = RD ? mem_word(BusDirecciones) : junk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic bit br_taken(input logic [3:0] cond, input logic n, input logic z,
                                  input logic v, input logic c);
    case (cond)
      4'd1: return bit'(z);   // be
      4'd5: return bit'(c);   // bcs
      4'd6: return bit'(n);   // bneg
      4'd7: return bit'(v);   // bvs
      4'd8: return 1'b1;      // ba
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk_br(input logic [3:0] cond, input int d);
    logic [21:0] d22;
    d22 = 22'(d);
    return {2'b00, 1'b0, cond, 3'b010, d22};
  endfunction

  task automatic step(input bit rand_start);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    junk = $urandom();
    {cc_n, cc_z, cc_v, cc_c} = 4'($urandom());
    if (rand_start) start = 1'($urandom());
    check_eq("wr", WR, 32'h0);
  endtask

  task automatic do_reset();
    RESET_InHigh = 1'b1;
    #1;
    check_eq("rst_rd", RD, 0);
    check_eq("rst_addr", BusDirecciones, 0);
    check_eq("rst_pc", PC, RPC);
    check_eq("rst_ir", IR, 0);
    check_eq("rst_es", exec_start, 0);
    check_eq("rst_halted", halted, 0);
    start = 1'b0;
    exec_done = 1'b0;
    @(negedge CLOCK_50);
    RESET_InHigh = 1'b0;
  endtask

  // Walks the program one instruction at a time; ends with the DUT reset back to IDLE.
  task automatic run_prog(input int max_instr, input int abort_at, input bit abort_fetch);
    logic [31:0] mpc, w;
    int lat, d, nidle;
    bit taken;
    start = 1'b0;
    nidle = $urandom_range(0, 3);
    for (int j = 0; j < nidle; j++) begin
      step(1'b0);
      check_eq("idle_rd", RD, 0);
      check_eq("idle_pc", PC, RPC);
    end
    start = 1'b1;
    step(1'b1);
    mpc = RPC;
    for (int i = 0; i < max_instr; i++) begin
      for (int k = 0; k <= MW; k++) begin
        check_eq("fetch_rd", RD, 1);
        check_eq("fetch_addr", BusDirecciones, mpc);
        check_eq("fetch_pc", PC, mpc);
        check_eq("fetch_es", exec_start, 0);
        check_eq("fetch_halted", halted, 0);
        if (abort_fetch && i == abort_at && k == MW) begin
          do_reset();
          return;
        end
        step(1'b1);
      end
      w = mem_word(mpc);
      check_eq("decode_ir", IR, w);
      check_eq("decode_rd", RD, 0);
      check_eq("decode_es", exec_start, 0);
      check_eq("decode_halted", halted, 0);
      if (w == 32'h0) begin
        for (int k = 0; k < 4; k++) begin
          step(1'b1);
          check_eq("halt_halted", halted, 1);
          check_eq("halt_rd", RD, 0);
          check_eq("halt_es", exec_start, 0);
          check_eq("halt_pc", PC, mpc);
          check_eq("halt_ir", IR, 0);
        end
        do_reset();
        return;
      end
      step(1'b1);
      if (w[31:30] == 2'b00 && w[24:22] == 3'b010) begin
        check_eq("branch_es", exec_start, 0);
        check_eq("branch_rd", RD, 0);
        check_eq("branch_pc", PC, mpc);
        if (!abort_fetch && i == abort_at) begin
          do_reset();
          return;
        end
        taken = br_taken(w[28:25], cc_n, cc_z, cc_v, cc_c);
        d = int'(w[21:0]);
        if (w[21]) d = d - (1 << 22);
        mpc = taken ? mpc + 32'(d) : mpc + 32'd4;
        step(1'b1);
      end else begin
        check_eq("exec_es", exec_start, 1);
        check_eq("exec_rd", RD, 0);
        exec_done = 1'($urandom());
        lat = $urandom_range(0, 3);
        step(1'b1);
        exec_done = 1'b0;
        if (!abort_fetch && i == abort_at) begin
          do_reset();
          return;
        end
        for (int j = 0; j < lat; j++) begin
          check_eq("wait_es", exec_start, 0);
          check_eq("wait_rd", RD, 0);
          check_eq("wait_pc", PC, mpc);
          step(1'b1);
        end
        exec_done = 1'b1;
        check_eq("wait_es", exec_start, 0);
        step(1'b1);
        exec_done = 1'b0;
        mpc = mpc + 32'd4;
      end
    end
    do_reset();
  endtask

  task automatic gen_prog();
    logic [31:0] x, w;
    int r, d;
    for (int i = 0; i < NWORDS; i++) begin
      r = $urandom_range(0, 15);
      x = $urandom();
      if (r == 0) begin
        w = 32'h0;
      end else if (r < 6) begin
        d = ($urandom_range(0, 16) - 8) * 4;
        if (r == 5 && x[0]) d = d + 2;
        w = mk_br(x[28:25], d);
      end else if (r < 8) begin
        w = x;
        w[31:30] = 2'b00;
        if (w[24:22] == 3'b010) w[22] = 1'b1;
        w[5] = 1'b1;
      end else if (r < 10) begin
        w = x;
        w[31:30] = 2'($urandom_range(1, 3));
        w[24:22] = 3'b010;
      end else begin
        w = x;
        if (w[31:30] == 2'b00) w[31] = 1'b1;
      end
      prog[i] = w;
    end
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) prog[i] = 32'h0;
    for (int i = 0; i < 4; i++) hiw[i] = ALU_W;
    RESET_InHigh = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    do_reset();

    // ALU word then fin at 0x804
    prog[0] = ALU_W;
    prog[1] = 32'h0;
    run_prog(10, -1, 1'b0);

    // bneg at 0x820, be at 0x834, ba at 0x83C, fin at 0x840
    for (int i = 0; i < NWORDS; i++) prog[i] = ALU_W;
    prog[8]  = 32'h0CBF_FFF0;
    prog[13] = 32'h0280_000C;
    prog[15] = 32'h10BF_FFE8;
    prog[16] = 32'h0;
    run_prog(40, -1, 1'b0);
    run_prog(40, -1, 1'b0);

    // ba to 0xFFFFFFF8, two ALU words, PC wraps to 0 which reads as fin
    for (int i = 0; i < NWORDS; i++) prog[i] = 32'h0;
    prog[0] = mk_br(4'b1000, -2056);
    run_prog(10, -1, 1'b0);

    // reset during a WAIT and during a BRANCH
    for (int i = 0; i < NWORDS; i++) prog[i] = ALU_W;
    prog[1] = mk_br(4'b1000, 8);
    run_prog(10, 0, 1'b0);
    run_prog(10, 1, 1'b0);
    run_prog(10, 2, 1'b1);

    for (int t = 0; t < 40; t++) begin
      gen_prog();
      if ($urandom_range(0, 2) == 0)
        run_prog(40, $urandom_range(0, 15), 1'($urandom()));
      else
        run_prog(40, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
